traffic_phase_timer: RTL and testbench



---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_dur_regs.sv | 48 ++++
 rtl/traffic_phase_timer.sv | 78 +++++++
 tb/tb_traffic_phase_timer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light FSM and its phase timer.
// State codes, duration-select codes and the minimum legal dwell.
package traffic_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3
  } state_e;

  localparam logic [1:0] SEL_GREEN_A  = 2'd0;
  localparam logic [1:0] SEL_YELLOW_A = 2'd1;
  localparam logic [1:0] SEL_GREEN_B  = 2'd2;
  localparam logic [1:0] SEL_YELLOW_B = 2'd3;

  localparam int DUR_MIN = 2;

  function automatic logic is_legal(input logic [2:0] s);
    return s <= 3'(S3);
  endfunction

endpackage

// File: rtl/traffic_dur_regs.sv
// Four-entry phase duration bank, clamped to DUR_MIN on write,
// with a combinational read port indexed by the current phase.
module traffic_dur_regs
  import traffic_pkg::*;
#(
  parameter int CW = 6,
  parameter int D0 = 10,
  parameter int D1 = 3,
  parameter int D2 = 10,
  parameter int D3 = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [1:0]    sel_i,
  input  logic [CW-1:0] wdata_i,
  input  logic [1:0]    rd_sel_i,
  output logic [CW-1:0] rd_data_o
);

  logic [3:0][CW-1:0] dur_q;
  logic [3:0][CW-1:0] dur_d;

  // A dwell below DUR_MIN would require loading a negative count.
  function automatic logic [CW-1:0] clamp_min(input logic [CW-1:0] v);
    return (v < CW'(DUR_MIN)) ? CW'(DUR_MIN) : v;
  endfunction

  always_comb begin
    dur_d = dur_q;
    if (we_i) dur_d[sel_i] = clamp_min(wdata_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dur_q[SEL_GREEN_A]  <= CW'(D0);
      dur_q[SEL_YELLOW_A] <= CW'(D1);
      dur_q[SEL_GREEN_B]  <= CW'(D2);
      dur_q[SEL_YELLOW_B] <= CW'(D3);
    end else begin
      dur_q <= dur_d;
    end
  end

  // Reads the pre-write value, so a same-cycle load sees the old duration.
  assign rd_data_o = dur_q[rd_sel_i];

endmodule

// File: rtl/traffic_phase_timer.sv
// Per-phase countdown that produces the green/yellow expiry inputs of the
// traffic light FSM, plus a seconds-remaining value for the display.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CW       = 6,
  parameter int GREEN_A  = 10,
  parameter int YELLOW_A = 3,
  parameter int GREEN_B  = 10,
  parameter int YELLOW_B = 3
) (
  input  logic          clk_1hz,
  input  logic          rst,
  input  logic [2:0]    state,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [CW-1:0] cfg_data,
  output logic          time1,
  output logic          time2,
  output logic [CW-1:0] remaining,
  output logic          illegal_state
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] dur_rd;
  logic          legal, match, change, expired;

  traffic_dur_regs #(
    .CW(CW), .D0(GREEN_A), .D1(YELLOW_A), .D2(GREEN_B), .D3(YELLOW_B)
  ) u_dur (
    .clk_i     (clk_1hz),
    .rst_i     (rst),
    .we_i      (cfg_we),
    .sel_i     (cfg_sel),
    .wdata_i   (cfg_data),
    .rd_sel_i  (state[1:0]),
    .rd_data_o (dur_rd)
  );

  assign legal   = is_legal(state);
  assign match   = legal && (state == state_q);
  assign change  = legal && (state != state_q);
  assign expired = match && (cnt_q == '0);

  // The change cycle itself is the first cycle of the new phase, hence -2.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (change) begin
      cnt_d   = dur_rd - CW'(DUR_MIN);
      state_d = state;
    end else if (match && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      cnt_q   <= CW'(GREEN_A - 1);
      state_q <= 3'(S0);
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign time1         = expired && !state[0];
  assign time2         = expired && state[0];
  assign illegal_state = !legal;

  always_comb begin
    remaining = '0;
    if (match)       remaining = cnt_q + CW'(1);
    else if (change) remaining = dur_rd;
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: a per-cycle reference model of
// phase dwell times plus literal checks on hand-worked sequences.
module tb_traffic_phase_timer;

  localparam int CW = 6;
  localparam int GA = 5;
  localparam int YA = 2;
  localparam int GB = 5;
  localparam int YB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    state;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic          time1, time2, illegal_state;
  logic [CW-1:0] remaining;

  int total = 0;
  int bad   = 0;

  traffic_phase_timer #(
    .CW(CW), .GREEN_A(GA), .YELLOW_A(YA), .GREEN_B(GB), .YELLOW_B(YB)
  ) dut (
    .clk_1hz       (clk),
    .rst           (rst),
    .state         (state),
    .cfg_we        (cfg_we),
    .cfg_sel       (cfg_sel),
    .cfg_data      (cfg_data),
    .time1         (time1),
    .time2         (time2),
    .remaining     (remaining),
    .illegal_state (illegal_state)
  );

  always #5 clk = ~clk;

  // Model: current phase, cycles left in it (including this one), durations.
  int m_dur [4];
  int m_phase;
  int m_left;
  bit m_valid = 0;

  always @(negedge clk) begin
    int s, e_rem, v;
    bit e_t1, e_t2, e_ill;
    s = int'(state);
    if (m_valid) begin
      e_ill = (s > 3);
      e_t1  = 0;
      e_t2  = 0;
      if (e_ill)             e_rem = 0;
      else if (s != m_phase) e_rem = m_dur[s];
      else begin
        e_rem = m_left;
        e_t1  = (m_left == 1) && (s % 2 == 0);
        e_t2  = (m_left == 1) && (s % 2 == 1);
      end
      total += 4;
      if (int'(remaining) != e_rem) begin
        bad++; $display("FAIL model_remaining t=%0t got=%0d exp=%0d", $time, remaining, e_rem);
      end
      if (time1 != e_t1) begin
        bad++; $display("FAIL model_time1 t=%0t got=%0d exp=%0d", $time, time1, e_t1);
      end
      if (time2 != e_t2) begin
        bad++; $display("FAIL model_time2 t=%0t got=%0d exp=%0d", $time, time2, e_t2);
      end
      if (illegal_state != e_ill) begin
        bad++; $display("FAIL model_illegal t=%0t got=%0d exp=%0d", $time, illegal_state, e_ill);
      end
    end
    if (rst) begin
      m_dur[0] = GA; m_dur[1] = YA; m_dur[2] = GB; m_dur[3] = YB;
      m_phase = 0;
      m_left  = GA;
      m_valid = 1;
    end else if (m_valid) begin
      if (s <= 3) begin
        if (s != m_phase) begin
          m_phase = s;
          m_left  = m_dur[s] - 1;
        end else if (m_left > 1) begin
          m_left--;
        end
      end
      if (cfg_we) begin
        v = int'(cfg_data);
        m_dur[cfg_sel] = (v < 2) ? 2 : v;
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int s, input int n);
    state = 3'(s);
    repeat (n) tick();
  endtask

  initial begin
    int runs[$];
    int rl;
    logic t1, t2;
    logic [2:0] nx;

    rst = 1'b1; state = 3'd0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Held in S0 after reset: 5,4,3,2,1,1,1 with time1 from cycle 4
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      lit("rst_remaining", int'(remaining), (i < 5) ? 5 - i : 1);
      lit("rst_time1", int'(time1), (i >= 4) ? 1 : 0);
      lit("rst_time2", int'(time2), 0);
      tick();
    end

    // Closed loop with a minimal FSM
    rl = 1;
    repeat (32) begin
      @(negedge clk);
      t1 = time1; t2 = time2; nx = state;
      if (t1 && state == 3'd0)      nx = 3'd1;
      else if (t2 && state == 3'd1) nx = 3'd2;
      else if (t1 && state == 3'd2) nx = 3'd3;
      else if (t2 && state == 3'd3) nx = 3'd0;
      @(posedge clk); #1;
      if (nx != state) begin runs.push_back(rl); rl = 1; end
      else rl++;
      state = nx;
    end
    lit("loop_runs", (runs.size() >= 5) ? 1 : 0, 1);
    if (runs.size() >= 5) begin
      lit("dwell_S1", runs[1], 2);
      lit("dwell_S2", runs[2], 5);
      lit("dwell_S3", runs[3], 2);
      lit("dwell_S0", runs[4], 5);
      lit("period", runs[1] + runs[2] + runs[3] + runs[4], 14);
    end

    // Emergency jump S2 -> S0 after three S2 cycles
    hold(1, 1);
    hold(2, 3);
    state = 3'd0;
    @(negedge clk);
    lit("emg_remaining", int'(remaining), 5);
    lit("emg_time1", int'(time1), 0);
    lit("emg_time2", int'(time2), 0);
    tick();
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      lit("emg_s0_time1", int'(time1), (k == 5) ? 1 : 0);
      tick();
    end

    // Reprogram GREEN_B mid-S2; clamp of a zero YELLOW_A write
    hold(2, 2);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 6'd8;
    @(negedge clk);
    lit("cfg_rem3", int'(remaining), 3);
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    lit("cfg_rem2", int'(remaining), 2);
    tick();
    @(negedge clk);
    lit("cfg_old_end", int'(time1), 1);
    tick();
    state = 3'd3; cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 6'd0;
    tick();
    cfg_we = 1'b0;
    tick();
    hold(0, 5);
    state = 3'd1;
    @(negedge clk);
    lit("clamp_s1_dur", int'(remaining), 2);
    tick(); tick();
    state = 3'd2;
    @(negedge clk);
    lit("new_s2_dur", int'(remaining), 8);
    repeat (8) tick();
    hold(3, 2);

    // Illegal state excursion mid-S1 (YELLOW_A set to 4 first)
    state = 3'd0; cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 6'd4;
    tick();
    cfg_we = 1'b0;
    repeat (4) tick();
    state = 3'd1;
    @(negedge clk);
    lit("ill_s1_start", int'(remaining), 4);
    tick();
    tick();
    state = 3'd5;
    repeat (3) begin
      @(negedge clk);
      lit("ill_flag", int'(illegal_state), 1);
      lit("ill_remaining", int'(remaining), 0);
      lit("ill_time", int'(time1) + int'(time2), 0);
      tick();
    end
    state = 3'd1;
    @(negedge clk);
    lit("ill_resume", int'(remaining), 2);
    lit("ill_clear", int'(illegal_state), 0);
    tick();
    @(negedge clk);
    lit("ill_resume_t2", int'(time2), 1);
    tick();
    state = 3'd3;
    @(negedge clk);
    lit("ill_s3_reload", int'(remaining), 2);
    tick();
    @(negedge clk);
    lit("ill_s3_t2", int'(time2), 1);
    tick();

    // Reset mid-S3 together with a config write
    rst = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 6'd7;
    tick();
    rst = 1'b0; cfg_we = 1'b0; state = 3'd0;
    @(negedge clk);
    lit("rst2_remaining", int'(remaining), 5);
    lit("rst2_time1", int'(time1), 0);
    repeat (4) tick();
    @(negedge clk);
    lit("rst2_t1", int'(time1), 1);
    tick();
    state = 3'd1;
    @(negedge clk);
    lit("rst2_s1_param", int'(remaining), 2);
    tick(); tick();
    hold(2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
